// File: rtl/logic_op_sequencer.sv
// ============================================================================
// logic_op_sequencer : fetch/decode/execute control for and/or/andi/ori/neg/not
// Revision: 1.0
// ============================================================================
`default_nettype none

module logic_op_sequencer #(
    parameter logic [4:0]  OPC_AND    = 5'b00101,
    parameter logic [4:0]  OPC_OR     = 5'b00110,
    parameter logic [4:0]  OPC_ANDI   = 5'b01100,
    parameter logic [4:0]  OPC_ORI    = 5'b01101,
    parameter logic [4:0]  OPC_NEG    = 5'b10001,
    parameter logic [4:0]  OPC_NOT    = 5'b10010,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       run,
    input  logic       mem_ready,
    input  logic [4:0] opcode,
    output logic       pc_out,
    output logic       mar_in,
    output logic       inc_pc,
    output logic       z_in,
    output logic       zlo_out,
    output logic       pc_in,
    output logic       mem_read,
    output logic       mdr_in,
    output logic       mdr_out,
    output logic       ir_in,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       r_out,
    output logic       r_in,
    output logic       y_in,
    output logic       c_out,
    output logic       alu_and,
    output logic       alu_or,
    output logic       alu_neg,
    output logic       alu_not,
    output logic       busy,
    output logic       illegal
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_DEC   = 4'd4;
    localparam logic [3:0] S_T3    = 4'd5;
    localparam logic [3:0] S_T4    = 4'd6;
    localparam logic [3:0] S_T5    = 4'd7;
    localparam logic [3:0] S_FAULT = 4'd8;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_AND3 = 3'd1;
    localparam logic [2:0] OP_OR3  = 3'd2;
    localparam logic [2:0] OP_ANDI = 3'd3;
    localparam logic [2:0] OP_ORI  = 3'd4;
    localparam logic [2:0] OP_NEG  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;

    // A limit beyond what the saturating 5-bit counter can reach never fires.
    localparam bit         LIMIT_ON = (WAIT_LIMIT != 0) && (WAIT_LIMIT <= 32);
    localparam logic [5:0] LIMIT6   = 6'(WAIT_LIMIT);
    localparam logic [4:0] WCNT_MAX = 5'd31;

    logic [3:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [4:0] wcnt_q, wcnt_d;

    logic [2:0] dec_op;
    logic [5:0] wcnt_inc;
    logic       timeout;
    logic       op_unary;
    logic       op_imm;
    logic       sel_and;
    logic       sel_or;

    always_comb begin
        dec_op = OP_NONE;
        case (opcode)
            OPC_AND:  dec_op = OP_AND3;
            OPC_OR:   dec_op = OP_OR3;
            OPC_ANDI: dec_op = OP_ANDI;
            OPC_ORI:  dec_op = OP_ORI;
            OPC_NEG:  dec_op = OP_NEG;
            OPC_NOT:  dec_op = OP_NOT;
            default:  dec_op = OP_NONE;
        endcase
    end

    assign wcnt_inc = {1'b0, wcnt_q} + 6'd1;
    assign timeout  = LIMIT_ON && !mem_ready && (wcnt_inc == LIMIT6);

    assign op_unary = (op_q == OP_NEG) || (op_q == OP_NOT);
    assign op_imm   = (op_q == OP_ANDI) || (op_q == OP_ORI);
    assign sel_and  = (op_q == OP_AND3) || (op_q == OP_ANDI);
    assign sel_or   = (op_q == OP_OR3) || (op_q == OP_ORI);

    // State, op class and wait counter registers
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
            wcnt_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                state_d = S_T1;
                wcnt_d  = 5'd0;
            end
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                end else begin
                    if (wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + 5'd1;
                    if (timeout) state_d = S_FAULT;
                end
            end
            S_T2: state_d = S_DEC;
            S_DEC: begin
                op_d    = dec_op;
                state_d = (dec_op == OP_NONE) ? S_FAULT : S_T3;
            end
            S_T3: state_d = S_T4;
            S_T4: begin
                if (op_unary) state_d = run ? S_T0 : S_IDLE;
                else          state_d = S_T5;
            end
            S_T5:    state_d = run ? S_T0 : S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: only state, op class and the first-T1 marker (wcnt_q==0)
    always_comb begin
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        pc_in    = 1'b0;
        mem_read = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        gra      = 1'b0;
        grb      = 1'b0;
        grc      = 1'b0;
        r_out    = 1'b0;
        r_in     = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        alu_and  = 1'b0;
        alu_or   = 1'b0;
        alu_neg  = 1'b0;
        alu_not  = 1'b0;
        busy     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_T0: begin
                busy   = 1'b1;
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                busy     = 1'b1;
                zlo_out  = 1'b1;
                pc_in    = (wcnt_q == 5'd0);
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                busy    = 1'b1;
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_DEC: busy = 1'b1;
            S_T3: begin
                busy  = 1'b1;
                grb   = 1'b1;
                r_out = 1'b1;
                if (op_unary) begin
                    z_in    = 1'b1;
                    alu_neg = (op_q == OP_NEG);
                    alu_not = (op_q == OP_NOT);
                end else begin
                    y_in = 1'b1;
                end
            end
            S_T4: begin
                busy = 1'b1;
                if (op_unary) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else begin
                    z_in    = 1'b1;
                    alu_and = sel_and;
                    alu_or  = sel_or;
                    if (op_imm) begin
                        c_out = 1'b1;
                    end else begin
                        grc   = 1'b1;
                        r_out = 1'b1;
                    end
                end
            end
            S_T5: begin
                busy    = 1'b1;
                zlo_out = 1'b1;
                gra     = 1'b1;
                r_in    = 1'b1;
            end
            S_FAULT: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_op_sequencer.sv
// ============================================================================
// tb_logic_op_sequencer : directed scoreboard bench for logic_op_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_logic_op_sequencer;

    logic       clock = 1'b0;
    logic       clear;
    logic       run;
    logic       mem_ready;
    logic [4:0] opcode;

    logic pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in;
    logic mem_read, mdr_in, mdr_out, ir_in;
    logic gra, grb, grc, r_out, r_in, y_in, c_out;
    logic alu_and, alu_or, alu_neg, alu_not, busy, illegal;

    logic_op_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .run       (run),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .pc_out    (pc_out),
        .mar_in    (mar_in),
        .inc_pc    (inc_pc),
        .z_in      (z_in),
        .zlo_out   (zlo_out),
        .pc_in     (pc_in),
        .mem_read  (mem_read),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .gra       (gra),
        .grb       (grb),
        .grc       (grc),
        .r_out     (r_out),
        .r_in      (r_in),
        .y_in      (y_in),
        .c_out     (c_out),
        .alu_and   (alu_and),
        .alu_or    (alu_or),
        .alu_neg   (alu_neg),
        .alu_not   (alu_not),
        .busy      (busy),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    localparam logic [22:0] M_PC_OUT   = 23'(1) << 22;
    localparam logic [22:0] M_MAR_IN   = 23'(1) << 21;
    localparam logic [22:0] M_INC_PC   = 23'(1) << 20;
    localparam logic [22:0] M_Z_IN     = 23'(1) << 19;
    localparam logic [22:0] M_ZLO_OUT  = 23'(1) << 18;
    localparam logic [22:0] M_PC_IN    = 23'(1) << 17;
    localparam logic [22:0] M_MEM_READ = 23'(1) << 16;
    localparam logic [22:0] M_MDR_IN   = 23'(1) << 15;
    localparam logic [22:0] M_MDR_OUT  = 23'(1) << 14;
    localparam logic [22:0] M_IR_IN    = 23'(1) << 13;
    localparam logic [22:0] M_GRA      = 23'(1) << 12;
    localparam logic [22:0] M_GRB      = 23'(1) << 11;
    localparam logic [22:0] M_GRC      = 23'(1) << 10;
    localparam logic [22:0] M_R_OUT    = 23'(1) << 9;
    localparam logic [22:0] M_R_IN     = 23'(1) << 8;
    localparam logic [22:0] M_Y_IN     = 23'(1) << 7;
    localparam logic [22:0] M_C_OUT    = 23'(1) << 6;
    localparam logic [22:0] M_ALU_AND  = 23'(1) << 5;
    localparam logic [22:0] M_ALU_OR   = 23'(1) << 4;
    localparam logic [22:0] M_ALU_NEG  = 23'(1) << 3;
    localparam logic [22:0] M_ALU_NOT  = 23'(1) << 2;
    localparam logic [22:0] M_BUSY     = 23'(1) << 1;
    localparam logic [22:0] M_ILLEGAL  = 23'(1);

    localparam logic [22:0] E_IDLE  = 23'd0;
    localparam logic [22:0] E_T0    = M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN | M_BUSY;
    localparam logic [22:0] E_T1F   = M_ZLO_OUT | M_PC_IN | M_MEM_READ | M_MDR_IN | M_BUSY;
    localparam logic [22:0] E_T1W   = M_ZLO_OUT | M_MEM_READ | M_MDR_IN | M_BUSY;
    localparam logic [22:0] E_T2    = M_MDR_OUT | M_IR_IN | M_BUSY;
    localparam logic [22:0] E_DEC   = M_BUSY;
    localparam logic [22:0] E_T3B   = M_GRB | M_R_OUT | M_Y_IN | M_BUSY;
    localparam logic [22:0] E_T3NOT = M_GRB | M_R_OUT | M_Z_IN | M_ALU_NOT | M_BUSY;
    localparam logic [22:0] E_T3NEG = M_GRB | M_R_OUT | M_Z_IN | M_ALU_NEG | M_BUSY;
    localparam logic [22:0] E_T4AND = M_GRC | M_R_OUT | M_Z_IN | M_ALU_AND | M_BUSY;
    localparam logic [22:0] E_T4ORI = M_C_OUT | M_Z_IN | M_ALU_OR | M_BUSY;
    localparam logic [22:0] E_WB    = M_ZLO_OUT | M_GRA | M_R_IN | M_BUSY;
    localparam logic [22:0] E_FLT   = M_ILLEGAL;

    localparam logic [4:0] O_AND = 5'b00101;
    localparam logic [4:0] O_ORI = 5'b01101;
    localparam logic [4:0] O_NEG = 5'b10001;
    localparam logic [4:0] O_NOT = 5'b10010;
    localparam logic [4:0] O_BAD = 5'b11111;

    logic [22:0] obs;
    assign obs = {pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mem_read, mdr_in,
                  mdr_out, ir_in, gra, grb, grc, r_out, r_in, y_in, c_out,
                  alu_and, alu_or, alu_neg, alu_not, busy, illegal};

    logic [22:0] exp_q[$];
    int          id_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          step_no = 0;

    // One cycle: record what the outputs must be now, then set this cycle's inputs.
    task automatic step(input logic clr, input logic r, input logic mr,
                        input logic [4:0] opc, input logic [22:0] e);
        exp_q.push_back(e);
        id_q.push_back(step_no);
        step_no++;
        clear     = clr;
        run       = r;
        mem_ready = mr;
        opcode    = opc;
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        logic [22:0] e;
        int          id;
        logic        inv_ok;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL step %0d outputs: got %06h required %06h", id, obs, e);
            end
            inv_ok = ($countones({alu_and, alu_or, alu_neg, alu_not}) <= 1)
                  && (!(alu_and | alu_or | alu_neg | alu_not) || z_in)
                  && !(r_out && r_in)
                  && ($countones({gra, grb, grc}) <= 1);
            n_cmp++;
            if (inv_ok !== 1'b1) begin
                n_bad++;
                $display("FAIL step %0d invariants: got %b required 1", id, inv_ok);
            end
        end
    end

    initial begin
        clear     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 5'd0;
        repeat (2) @(posedge clock);
        #1;

        // and: 7 cycles, busy drops in cycle 8
        step(0, 1, 1, O_AND, E_IDLE);
        step(0, 0, 1, O_AND, E_T0);
        step(0, 0, 1, O_AND, E_T1F);
        step(0, 0, 1, O_AND, E_T2);
        step(0, 0, 1, O_AND, E_DEC);
        step(0, 0, 1, O_AND, E_T3B);
        step(0, 0, 1, O_AND, E_T4AND);
        step(0, 0, 1, O_AND, E_WB);

        // not: 6 cycles, no y_in
        step(0, 1, 1, O_NOT, E_IDLE);
        step(0, 0, 1, O_NOT, E_T0);
        step(0, 0, 1, O_NOT, E_T1F);
        step(0, 0, 1, O_NOT, E_T2);
        step(0, 0, 1, O_NOT, E_DEC);
        step(0, 0, 1, O_NOT, E_T3NOT);
        step(0, 0, 1, O_NOT, E_WB);

        // ori with three wait cycles in T1
        step(0, 1, 1, O_ORI, E_IDLE);
        step(0, 0, 0, O_ORI, E_T0);
        step(0, 0, 0, O_ORI, E_T1F);
        step(0, 0, 0, O_ORI, E_T1W);
        step(0, 0, 0, O_ORI, E_T1W);
        step(0, 0, 1, O_ORI, E_T1W);
        step(0, 0, 1, O_ORI, E_T2);
        step(0, 0, 1, O_ORI, E_DEC);
        step(0, 0, 1, O_ORI, E_T3B);
        step(0, 0, 1, O_ORI, E_T4ORI);
        step(0, 0, 1, O_ORI, E_WB);

        // illegal opcode: sticky FAULT until clear
        step(0, 1, 1, O_BAD, E_IDLE);
        step(0, 0, 1, O_BAD, E_T0);
        step(0, 0, 1, O_BAD, E_T1F);
        step(0, 0, 1, O_BAD, E_T2);
        step(0, 0, 1, O_BAD, E_DEC);
        step(0, 0, 1, O_BAD, E_FLT);
        step(0, 1, 1, O_BAD, E_FLT);
        step(0, 0, 1, O_AND, E_FLT);
        step(1, 1, 1, O_AND, E_FLT);

        // memory never ready: FAULT after exactly 16 T1 cycles
        step(0, 1, 0, O_AND, E_IDLE);
        step(0, 0, 0, O_AND, E_T0);
        step(0, 0, 0, O_AND, E_T1F);
        repeat (15) step(0, 0, 0, O_AND, E_T1W);
        step(1, 0, 0, O_AND, E_FLT);

        // clear in T4 of and, then restart with run held high
        step(0, 1, 1, O_AND, E_IDLE);
        step(0, 0, 1, O_AND, E_T0);
        step(0, 0, 1, O_AND, E_T1F);
        step(0, 0, 1, O_AND, E_T2);
        step(0, 0, 1, O_AND, E_DEC);
        step(0, 0, 1, O_AND, E_T3B);
        step(1, 1, 1, O_AND, E_T4AND);
        step(0, 1, 1, O_AND, E_IDLE);

        // back-to-back and then neg
        step(0, 1, 1, O_AND, E_T0);
        step(0, 1, 1, O_AND, E_T1F);
        step(0, 1, 1, O_AND, E_T2);
        step(0, 1, 1, O_AND, E_DEC);
        step(0, 1, 1, O_AND, E_T3B);
        step(0, 1, 1, O_AND, E_T4AND);
        step(0, 1, 1, O_NEG, E_WB);
        step(0, 0, 1, O_NEG, E_T0);
        step(0, 0, 1, O_NEG, E_T1F);
        step(0, 0, 1, O_NEG, E_T2);
        step(0, 0, 1, O_NEG, E_DEC);
        step(0, 0, 1, O_NEG, E_T3NEG);
        step(0, 0, 1, O_NEG, E_WB);
        step(0, 0, 1, O_NEG, E_IDLE);
        step(0, 0, 1, O_NEG, E_IDLE);

        repeat (3) @(negedge clock);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
